progmem_loader: RTL and testbench



---
 rtl/progmem_loader_if.sv | 31 +++
 rtl/progmem_loader.sv | 202 ++++++++++++++++++++
 tb/tb_progmem_loader.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/progmem_loader_if.sv
// rtl/progmem_loader_if.sv - byte stream, program memory write and CPU control bundle for progmem_loader
interface progmem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 40
);
  logic              i_start;
  logic              i_byte_valid;
  logic [7:0]        i_byte;
  logic              o_byte_ready;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [WORD_W-1:0] o_wr_data;
  logic              o_cpu_hold;
  logic              o_busy;
  logic              o_done;
  logic              o_error;

  // Source / host side: drives the stream and start, observes the loader.
  modport master (
    output i_start, i_byte_valid, i_byte,
    input  o_byte_ready, o_wr_en, o_wr_addr, o_wr_data,
    input  o_cpu_hold, o_busy, o_done, o_error
  );

  // Loader side.
  modport slave (
    input  i_start, i_byte_valid, i_byte,
    output o_byte_ready, o_wr_en, o_wr_addr, o_wr_data,
    output o_cpu_hold, o_busy, o_done, o_error
  );
endinterface

// File: rtl/progmem_loader.sv
// rtl/progmem_loader.sv - boot loader assembling a framed byte stream into program memory words (optional checksum: PROGMEM_LOADER_CHECKSUM_EN)
module progmem_loader #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 40
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  progmem_loader_if.slave    bus
);

  localparam int BPW   = WORD_W / 8;
  localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;
  // Word counter must hold both any count byte value and the full depth (count 0).
  localparam int CNT_W = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
`ifdef PROGMEM_LOADER_CHECKSUM_EN
    S_CHECK,
    S_ERROR,
`endif
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic [CNT_W-1:0]  left_q, left_d;
  logic [WORD_W-1:0] asm_q, asm_d;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              error_q, error_d;
`endif

  logic              accept;
  logic [WORD_W-1:0] shifted;
  logic [CNT_W-1:0]  n_words;

  assign accept  = bus.i_byte_valid && ready_q;
  // New byte enters at the LSB, so the first byte of a word ends up in the top byte.
  assign shifted = (asm_q << 8) | WORD_W'(bus.i_byte);
  assign n_words = (bus.i_byte == 8'd0) ? (CNT_W'(1) << ADDR_W) : CNT_W'(bus.i_byte);

  // Next-state and next-output computation for the load sequencer.
  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    done_d    = done_q;
    addr_d    = addr_q;
    bcnt_d    = bcnt_q;
    left_d    = left_q;
    asm_d     = asm_q;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    error_d   = error_q;
`endif
    case (state_q)
      S_IDLE,
`ifdef PROGMEM_LOADER_CHECKSUM_EN
      S_ERROR,
`endif
      S_DONE: begin
        if (bus.i_start) begin
          state_d = S_COUNT;
          ready_d = 1'b1;
          busy_d  = 1'b1;
          hold_d  = 1'b1;
          done_d  = 1'b0;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
          error_d = 1'b0;
`endif
        end
      end
      S_COUNT: begin
        if (accept) begin
          left_d  = n_words;
          addr_d  = '0;
          bcnt_d  = '0;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
          sum_d   = bus.i_byte;
`endif
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          asm_d = shifted;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
          sum_d = sum_q + bus.i_byte;
`endif
          if (bcnt_q == BC_W'(BPW - 1)) begin
            bcnt_d    = '0;
            wr_en_d   = 1'b1;
            wr_data_d = shifted;
            wr_addr_d = addr_q;
            addr_d    = addr_q + ADDR_W'(1);
            left_d    = left_q - CNT_W'(1);
            if (left_q == CNT_W'(1)) begin
`ifdef PROGMEM_LOADER_CHECKSUM_EN
              state_d = S_CHECK;
`else
              // Hold release coincides with the last write strobe.
              state_d = S_DONE;
              ready_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              hold_d  = 1'b0;
`endif
            end
          end else begin
            bcnt_d = bcnt_q + BC_W'(1);
          end
        end
      end
`ifdef PROGMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          ready_d = 1'b0;
          busy_d  = 1'b0;
          if (8'(sum_q + bus.i_byte) == 8'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
            hold_d  = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // All loader state and registered outputs; reset leaves the CPU held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      bcnt_q    <= '0;
      left_q    <= '0;
      asm_q     <= '0;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
      sum_q     <= '0;
      error_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
      bcnt_q    <= bcnt_d;
      left_q    <= left_d;
      asm_q     <= asm_d;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
      error_q   <= error_d;
`endif
    end
  end

  assign bus.o_byte_ready = ready_q;
  assign bus.o_wr_en      = wr_en_q;
  assign bus.o_wr_addr    = wr_addr_q;
  assign bus.o_wr_data    = wr_data_q;
  assign bus.o_cpu_hold   = hold_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
  assign bus.o_error      = error_q;
`else
  assign bus.o_error      = 1'b0;
`endif

endmodule

// File: tb/tb_progmem_loader.sv
// tb/tb_progmem_loader.sv - self-checking bench for progmem_loader (table vectors, random loads, corner sequences)
module tb_progmem_loader;

  localparam int ADDR_W = 8;
  localparam int WORD_W = 40;
  localparam int BPW    = WORD_W / 8;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  progmem_loader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus();

  progmem_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  int checks  = 0;
  int errors  = 0;
  int acc_cnt = 0;

  logic [ADDR_W-1:0] got_addr[$];
  logic [WORD_W-1:0] got_data[$];
  logic              got_hold[$];
  logic              got_done[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [WORD_W-1:0] exp_data[$];

  typedef struct {
    logic [7:0]        cnt;
    logic [WORD_W-1:0] w0;
    logic [WORD_W-1:0] w1;
    int                gap;
    int                en;
    logic [WORD_W-1:0] e0;
    logic [WORD_W-1:0] e1;
  } vec_t;

  // Observe acceptances and write strobes mid-cycle.
  always @(negedge clk) begin
    if (bus.i_byte_valid && bus.o_byte_ready) acc_cnt++;
    if (bus.o_wr_en) begin
      got_addr.push_back(bus.o_wr_addr);
      got_data.push_back(bus.o_wr_data);
      got_hold.push_back(bus.o_cpu_hold);
      got_done.push_back(bus.o_done);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_got();
    got_addr.delete(); got_data.delete(); got_hold.delete(); got_done.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, bus.o_byte_ready, 0);
    chk({tag, "_wr_en"}, bus.o_wr_en, 0);
    chk({tag, "_wr_addr"}, bus.o_wr_addr, 0);
    chk({tag, "_wr_data"}, bus.o_wr_data, 0);
    chk({tag, "_hold"}, bus.o_cpu_hold, 1);
    chk({tag, "_busy"}, bus.o_busy, 0);
    chk({tag, "_done"}, bus.o_done, 0);
    chk({tag, "_error"}, bus.o_error, 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    bus.i_byte = b;
    bus.i_byte_valid = 1'b1;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      got = bus.o_byte_ready;
      tick();
    end
    bus.i_byte_valid = 1'b0;
    if (!got) chk("byte_accept_timeout", 0, 1);
  endtask

  // Pulse start, stream every byte (gaps and stray start pulses in between), then let the last write land.
  task automatic run_load(input logic [7:0] s[$], input int gap_fixed, input int gap_rand, input bit noise);
    int a0;
    int g;
    clear_got();
    a0 = acc_cnt;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk("start_busy", bus.o_busy, 1);
    chk("start_ready", bus.o_byte_ready, 1);
    chk("start_hold", bus.o_cpu_hold, 1);
    chk("start_done", bus.o_done, 0);
    for (int i = 0; i < s.size(); i++) begin
      send_byte(s[i]);
      if (i != s.size() - 1) begin
        g = gap_fixed + ((gap_rand > 0) ? int'($urandom_range(gap_rand, 0)) : 0);
        for (int k = 0; k < g; k++) begin
          if (noise && $urandom_range(3, 0) == 0) bus.i_start = 1'b1;
          tick();
          bus.i_start = 1'b0;
        end
      end
    end
    tick();
    tick();
    chk("bytes_consumed", acc_cnt - a0, s.size());
  endtask

  // Reference: count byte N (0 = full depth), then N words of BPW bytes MSB first at addresses 0,1,...
  function automatic void model(input logic [7:0] s[$]);
    int n;
    logic [WORD_W-1:0] w;
    n = (s[0] == 8'd0) ? (1 << ADDR_W) : int'(s[0]);
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < n; i++) begin
      w = '0;
      for (int b = 0; b < BPW; b++) w = (w << 8) | WORD_W'(s[1 + i * BPW + b]);
      exp_addr.push_back(ADDR_W'(i % (1 << ADDR_W)));
      exp_data.push_back(w);
    end
  endfunction

  function automatic logic [7:0] csum(input logic [7:0] s[$]);
    logic [7:0] sum;
    sum = 8'd0;
    foreach (s[i]) sum = sum + s[i];
    return 8'(8'd0 - sum);
  endfunction

  task automatic verify(input string tag, input bit exp_err);
    bit fin;
    chk($sformatf("%s_nwrites", tag), got_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      fin = (i == exp_data.size() - 1) && !CK;
      chk($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
      chk($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
      chk($sformatf("%s_wrhold%0d", tag, i), got_hold[i], !fin);
      chk($sformatf("%s_wrdone%0d", tag, i), got_done[i], fin);
    end
    chk({tag, "_done"}, bus.o_done, !exp_err);
    chk({tag, "_hold"}, bus.o_cpu_hold, exp_err);
    chk({tag, "_busy"}, bus.o_busy, 0);
    chk({tag, "_ready"}, bus.o_byte_ready, 0);
    chk({tag, "_error"}, bus.o_error, exp_err);
  endtask

  vec_t       tbl[5];
  logic [7:0] s[$];
  int         a0;
  int         n;

  initial begin
    bus.i_start = 1'b0;
    bus.i_byte_valid = 1'b0;
    bus.i_byte = 8'h00;

    tbl[0] = '{8'h02, 40'h8000000141, 40'h000000002A, 0, 2, 40'h8000000141, 40'h000000002A};
    tbl[1] = '{8'h02, 40'h8000000141, 40'h000000002A, 1, 2, 40'h8000000141, 40'h000000002A};
    tbl[2] = '{8'h02, 40'h8000000141, 40'h000000002A, 5, 2, 40'h8000000141, 40'h000000002A};
    tbl[3] = '{8'h01, 40'hFFFFFFFFFF, 40'h0000000000, 2, 1, 40'hFFFFFFFFFF, 40'h0000000000};
    tbl[4] = '{8'h02, 40'h0123456789, 40'hFEDCBA9876, 3, 2, 40'h0123456789, 40'hFEDCBA9876};

    // Reset state and no consumption without a start.
    repeat (3) tick();
    check_reset_vals("in_reset");
    rst_n = 1'b1;
    tick();
    check_reset_vals("after_reset");
    clear_got();
    a0 = acc_cnt;
    bus.i_byte = 8'h55;
    bus.i_byte_valid = 1'b1;
    repeat (10) tick();
    bus.i_byte_valid = 1'b0;
    chk("idle_no_consume", acc_cnt - a0, 0);
    chk("idle_no_write", got_data.size(), 0);

    // Table vectors with fixed expected words.
    for (int v = 0; v < 5; v++) begin
      s.delete();
      s.push_back(tbl[v].cnt);
      for (int b = 0; b < BPW; b++) s.push_back(8'(tbl[v].w0 >> (8 * (BPW - 1 - b))));
      if (tbl[v].cnt == 8'h02)
        for (int b = 0; b < BPW; b++) s.push_back(8'(tbl[v].w1 >> (8 * (BPW - 1 - b))));
      if (CK) s.push_back(csum(s));
      run_load(s, tbl[v].gap, 0, 1'b0);
      exp_addr.delete();
      exp_data.delete();
      exp_addr.push_back(8'd0);
      exp_data.push_back(tbl[v].e0);
      if (tbl[v].en == 2) begin
        exp_addr.push_back(8'd1);
        exp_data.push_back(tbl[v].e1);
      end
      verify($sformatf("vec%0d", v), 1'b0);
    end

    // Random loads against the reference model, with stray start pulses.
    for (int r = 0; r < 10; r++) begin
      s.delete();
      n = int'($urandom_range(12, 1));
      s.push_back(8'(n));
      for (int i = 0; i < n * BPW; i++) s.push_back(8'($urandom));
      if (CK) s.push_back(csum(s));
      run_load(s, 0, 3, 1'b1);
      model(s);
      verify($sformatf("rnd%0d", r), 1'b0);
    end

    // Count byte 0: full depth, word value = index.
    s.delete();
    s.push_back(8'h00);
    for (int i = 0; i < 256; i++) begin
      for (int b = 0; b < BPW - 1; b++) s.push_back(8'h00);
      s.push_back(8'(i));
    end
    if (CK) s.push_back(csum(s));
    run_load(s, 0, 0, 1'b0);
    model(s);
    verify("full", 1'b0);

    // Stream bytes offered in DONE are not consumed.
    a0 = acc_cnt;
    bus.i_byte = 8'hA5;
    bus.i_byte_valid = 1'b1;
    repeat (5) tick();
    bus.i_byte_valid = 1'b0;
    chk("done_no_consume", acc_cnt - a0, 0);

    // Reset in the middle of word 1, then a fresh one-word load.
    clear_got();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midload_reset");
    chk("midload_no_write", got_data.size(), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_reset_vals("midload_release");
    s.delete();
    s.push_back(8'h01);
    s.push_back(8'hDE); s.push_back(8'hAD); s.push_back(8'hBE); s.push_back(8'hEF); s.push_back(8'h01);
    if (CK) s.push_back(csum(s));
    run_load(s, 0, 0, 1'b0);
    exp_addr.delete();
    exp_data.delete();
    exp_addr.push_back(8'd0);
    exp_data.push_back(40'hDEADBEEF01);
    verify("after_reset_load", 1'b0);

`ifdef PROGMEM_LOADER_CHECKSUM_EN
    // Checksum pass and fail on the same single-word image.
    s.delete();
    s.push_back(8'h01);
    s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'h05);
    s.push_back(8'hFA);
    run_load(s, 0, 0, 1'b0);
    exp_addr.delete();
    exp_data.delete();
    exp_addr.push_back(8'd0);
    exp_data.push_back(40'h0000000005);
    verify("ck_pass", 1'b0);
    s[6] = 8'hFB;
    run_load(s, 0, 0, 1'b0);
    verify("ck_fail", 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
